// File: rtl/vga_frame_scanout.sv
// 160x120x3 frame memory written by draw_frame, scanned out as 640x480@60 VGA with 4x4 pixel replication.
// Optional DOUBLE_BUFFER_EN: two banks, writes go to the back bank, swap at start of vblank.
module vga_frame_scanout #(
  parameter int COLS        = 160,
  parameter int ROWS        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] X,
  input  logic [6:0] Y,
  input  logic [2:0] color,
  input  logic       draw_enable,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_CLK,
`ifdef DOUBLE_BUFFER_EN
  input  logic       swap_req,
  output logic       front_bank,
`endif
  output logic       frame_tick
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int PIX      = COLS * ROWS;
  localparam int ADDR_W   = $clog2(PIX);
`ifdef DOUBLE_BUFFER_EN
  localparam int DEPTH    = 2 * PIX;
`else
  localparam int DEPTH    = PIX;
`endif
  localparam int MEM_AW   = $clog2(DEPTH);
  localparam int STAGES   = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  logic                   pix_en_q, pix_en_d;
  logic [H_W-1:0]         h_q, h_d;
  logic [V_W-1:0]         v_q, v_d;
  sync_t [STAGES:1]       sync_q, sync_d;
  sync_t                  sync_s0;
  logic [23:0]            rgb_q, rgb_d;
  logic                   vga_clk_q, vga_clk_d;
  logic                   frame_tick_q, frame_tick_d;
  logic                   visible, wr_en;
  logic [ADDR_W-1:0]      wr_addr, rd_addr;
  logic [MEM_AW-1:0]      wr_mem, rd_mem;
  logic [2:0]             rd_data_q;
  logic [2:0]             mem [DEPTH];
`ifdef DOUBLE_BUFFER_EN
  logic                   pend_q, pend_d;
  logic                   front_bank_q, front_bank_d;
  logic                   swap_now;
`endif

  always_comb begin
    pix_en_d  = ~pix_en_q;
    vga_clk_d = pix_en_q;
    h_d       = h_q;
    v_d       = v_q;
    if (pix_en_q) begin
      if (int'(h_q) == H_TOTAL - 1) begin
        h_d = '0;
        v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end
    end
    frame_tick_d = pix_en_q && (int'(h_q) == H_TOTAL - 1) && (int'(v_q) == V_VISIBLE - 1);

    visible         = (int'(h_q) < H_VISIBLE) && (int'(v_q) < V_VISIBLE);
    sync_s0.hs      = !((int'(h_q) >= HS_START) && (int'(h_q) < HS_START + H_SYNC));
    sync_s0.vs      = !((int'(v_q) >= VS_START) && (int'(v_q) < VS_START + V_SYNC));
    sync_s0.blank_n = visible;

    // Stage 1 lines up with the RAM read data, stage 2 with the registered RGB.
    sync_d[1] = sync_s0;
    for (int i = 2; i <= STAGES; i++) sync_d[i] = sync_q[i-1];
    rgb_d = sync_q[STAGES-1].blank_n ?
            {{8{rd_data_q[2]}}, {8{rd_data_q[1]}}, {8{rd_data_q[0]}}} : 24'h0;

    wr_en   = resetn && draw_enable && (int'(X) < COLS) && (int'(Y) < ROWS);
    wr_addr = ADDR_W'(int'(Y) * COLS + int'(X));
    rd_addr = ADDR_W'((int'(v_q) >> SCALE_SHIFT) * COLS + (int'(h_q) >> SCALE_SHIFT));

`ifdef DOUBLE_BUFFER_EN
    swap_now     = frame_tick_d && (pend_q || swap_req);
    pend_d       = swap_now ? 1'b0 : (pend_q || swap_req);
    front_bank_d = front_bank_q ^ swap_now;
    // Bank 0 occupies the low half of the array, bank 1 the high half.
    wr_mem = MEM_AW'(wr_addr) + (front_bank_q ? MEM_AW'(0) : MEM_AW'(PIX));
    rd_mem = MEM_AW'(rd_addr) + (front_bank_q ? MEM_AW'(PIX) : MEM_AW'(0));
`else
    wr_mem = MEM_AW'(wr_addr);
    rd_mem = MEM_AW'(rd_addr);
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pix_en_q     <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      sync_q       <= {STAGES{SYNC_IDLE}};
      rgb_q        <= '0;
      vga_clk_q    <= 1'b0;
      frame_tick_q <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
      pend_q       <= 1'b0;
      front_bank_q <= 1'b0;
`endif
    end else begin
      pix_en_q     <= pix_en_d;
      h_q          <= h_d;
      v_q          <= v_d;
      sync_q       <= sync_d;
      rgb_q        <= rgb_d;
      vga_clk_q    <= vga_clk_d;
      frame_tick_q <= frame_tick_d;
`ifdef DOUBLE_BUFFER_EN
      pend_q       <= pend_d;
      front_bank_q <= front_bank_d;
`endif
    end
  end

  // Read-before-write: a same-address collision returns the old contents.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_mem] <= color;
    if (visible) rd_data_q <= mem[rd_mem];
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = sync_q[STAGES].hs;
  assign VGA_VS      = sync_q[STAGES].vs;
  assign VGA_BLANK_N = sync_q[STAGES].blank_n;
  assign VGA_CLK     = vga_clk_q;
  assign frame_tick  = frame_tick_q;
`ifdef DOUBLE_BUFFER_EN
  assign front_bank  = front_bank_q;
`endif

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Scoreboard bench for vga_frame_scanout on a shrunken raster so several frames fit in a short run.
module tb_vga_frame_scanout;

  localparam int HV = 32, HF = 4, HSY = 8, HB = 4, HT = HV + HF + HSY + HB;   // 48
  localparam int VV = 36, VF = 2, VSY = 2, VB = 2, VT = VV + VF + VSY + VB;  // 42
  localparam int FRAME = 2 * HT * VT;
  localparam int LIMIT = 3 * FRAME;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] X = '0;
  logic [6:0] Y = '0;
  logic [2:0] color = '0;
  logic       draw_enable = 1'b0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frame_tick;
`ifdef DOUBLE_BUFFER_EN
  logic       swap_req = 1'b0;
  logic       front_bank;
`endif

  always #5 clock = ~clock;

  vga_frame_scanout #(
    .COLS(160), .ROWS(120), .SCALE_SHIFT(2),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .clock(clock), .resetn(resetn),
    .X(X), .Y(Y), .color(color), .draw_enable(draw_enable),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_CLK(VGA_CLK),
`ifdef DOUBLE_BUFFER_EN
    .swap_req(swap_req), .front_bank(front_bank),
`endif
    .frame_tick(frame_tick)
  );

  typedef struct {
    int          v;
    int          h;
    logic [23:0] rgb;
  } px_t;

  px_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic logic [2:0] pat(int x, int y);
    return 3'((x + 2 * y) % 8);
  endfunction

  function automatic logic [23:0] expand(logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  function automatic logic sig(int sel);
    case (sel)
      0:       return VGA_HS;
      1:       return VGA_VS;
      2:       return VGA_BLANK_N;
      default: return frame_tick;
    endcase
  endfunction

  task automatic check(string name, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_lvl(int sel, logic lvl);
    int n = 0;
    while (sig(sel) !== lvl && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    if (sig(sel) !== lvl) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_sig%0d: no level %0d after %0d cycles", sel, lvl, n);
    end
  endtask

  task automatic measure(int sel, logic lvl, output int len);
    wait_lvl(sel, !lvl);
    wait_lvl(sel, lvl);
    len = 0;
    while (sig(sel) === lvl && len < LIMIT) begin
      @(negedge clock);
      len++;
    end
  endtask

  task automatic wait_tick();
    wait_lvl(3, 1'b0);
    wait_lvl(3, 1'b1);
  endtask

  task automatic wr(int x, int y, logic [2:0] c);
    X = 8'(x); Y = 7'(y); color = c; draw_enable = 1'b1;
    @(negedge clock);
    draw_enable = 1'b0;
  endtask

  task automatic publish();
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b1;
    @(negedge clock);
    swap_req = 1'b0;
`endif
    wait_tick();
  endtask

  task automatic push(int v, int h, logic [23:0] rgb);
    px_t e;
    e.v = v; e.h = h; e.rgb = rgb;
    sb.push_back(e);
  endtask

  // Monitor: rebuilds the scan position from BLANK_N/VS only and pops expectations as they are shown.
  int   mon_line = -1;
  int   mon_run = 0;
  logic blank_prev = 1'b0;
  logic vs_prev = 1'b1;
  px_t  cur;

  always @(negedge clock) begin
    if (!resetn) begin
      mon_line = -1; mon_run = 0; blank_prev = 1'b0; vs_prev = 1'b1;
    end else begin
      if (vs_prev && !VGA_VS) mon_line = -1;
      if (VGA_BLANK_N) begin
        if (!blank_prev) begin
          mon_line++;
          mon_run = 0;
        end else begin
          mon_run++;
        end
        if (mon_run % 2 == 0 && sb.size() > 0 && sb[0].v == mon_line && sb[0].h == mon_run / 2) begin
          cur = sb.pop_front();
          vectors++;
          if ({VGA_R, VGA_G, VGA_B} !== cur.rgb) begin
            miscompares++;
            $display("FAIL pixel(h=%0d,v=%0d): got %06h, expected %06h", cur.h, cur.v,
                     {VGA_R, VGA_G, VGA_B}, cur.rgb);
          end
        end
      end else if (blank_prev && mon_line == 7) begin
        vectors++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
          miscompares++;
          $display("FAIL blank_rgb: got %06h, expected 000000", {VGA_R, VGA_G, VGA_B});
        end
      end
      blank_prev = VGA_BLANK_N;
      vs_prev    = VGA_VS;
    end
  end

  initial begin
    int n;
    logic a;

    repeat (4) @(negedge clock);
    check("rst_hs", int'(VGA_HS), 1);
    check("rst_vs", int'(VGA_VS), 1);
    check("rst_blank_n", int'(VGA_BLANK_N), 0);
    check("rst_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_vga_clk", int'(VGA_CLK), 0);
`ifdef DOUBLE_BUFFER_EN
    check("rst_front_bank", int'(front_bank), 0);
`endif
    resetn = 1'b1;

    // Known background over the visible mega-pixels (twice so both banks hold it when double buffered).
    for (int pass = 0; pass < 2; pass++) begin
      for (int y = 0; y < VV / 4; y++)
        for (int x = 0; x < HV / 4; x++) wr(x, y, pat(x, y));
      publish();
    end

    measure(0, 1'b0, n);  check("hs_low_len", n, 2 * HSY);
    measure(2, 1'b1, n);  check("blank_high_len", n, 2 * HV);
    wait_lvl(2, 1'b1);
    wait_lvl(2, 1'b0);
    n = 0;
    while (VGA_HS !== 1'b0 && n < LIMIT) begin @(negedge clock); n++; end
    check("hfront_porch", n, 2 * HF);
    a = VGA_CLK;
    @(negedge clock);
    check("vga_clk_toggle", int'(VGA_CLK), int'(!a));
    measure(1, 1'b0, n);  check("vs_low_len", n, 2 * VSY * HT);
    wait_tick();
    n = 0;
    while (VGA_VS !== 1'b0 && n < LIMIT) begin @(negedge clock); n++; end
    check("tick_to_vs", n, 2 * HT * VF + 2);
    measure(3, 1'b1, n);  check("tick_width", n, 1);
    wait_tick();
    n = 0;
    do begin @(negedge clock); n++; end while (frame_tick !== 1'b1 && n < LIMIT);
    check("tick_period", n, FRAME);

    // Basic write: mega-pixel (5,7) covers h=20..23, v=28..31; h=24 keeps the background.
    wr(5, 7, 3'b101);
    publish();
    for (int v = 28; v < 32; v++)
      for (int h = 20; h < 25; h++)
        push(v, h, (h < 24) ? 24'hFF00FF : expand(pat(6, 7)));
    wait_tick();

    // Out-of-range writes must not alias onto (0,1) or (0,0).
    wr(160, 0, 3'b111);
    wr(0, 120, 3'b111);
    publish();
    push(0, 0, expand(pat(0, 0)));
    push(4, 0, expand(pat(0, 1)));
    wait_tick();

    // Reset around v=20, then the next tick must come a full visible field later.
    wait_tick();
    repeat (2 * HT * (VT - VV + 20)) @(negedge clock);
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("midrst_blank_n", int'(VGA_BLANK_N), 0);
    resetn = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (frame_tick !== 1'b1 && n < LIMIT);
    check("midrst_to_tick", n, 2 * HT * VV);
    push(4, 0, expand(pat(0, 1)));
    wait_tick();

`ifdef DOUBLE_BUFFER_EN
    wr(0, 0, 3'b010);
    push(0, 0, expand(pat(0, 0)));
    wait_tick();
    check("db_no_swap", int'(front_bank), 0);
    swap_req = 1'b1; @(negedge clock); swap_req = 1'b0;
    repeat (5) @(negedge clock);
    swap_req = 1'b1; @(negedge clock); swap_req = 1'b0;
    wait_tick();
    check("db_swapped", int'(front_bank), 1);
    push(0, 0, 24'h00FF00);
    wait_tick();
    check("db_single_swap", int'(front_bank), 1);
`endif

    while (sb.size() > 0) begin
      cur = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL pixel(h=%0d,v=%0d): never scanned, expected %06h", cur.h, cur.v, cur.rgb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
